rca_multiword_add_ctrl: RTL and testbench
=========================================

Name: rca_multiword_add_ctrl

Overview:
- Sequencer that performs wide additions (32*WORDS bits) by time-multiplexing one ripple_carry_adder_32bit instance, one 32-bit word per cycle, least-significant word first.
- Carry is chained between words through a carry register.
- Sits between a wide-operand producer and consumer. Valid/ready handshake on both sides; one operation in flight.

Parameters:
- WORDS, 4, number of 32-bit words per operand (>=1); operand width W = 32*WORDS.

Ports:
- clk  input  1  clock, all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operands valid.
- in_ready  output  1  controller can accept operands.
- a  input  W  operand A.
- b  input  W  operand B.
- cin  input  1  carry into word 0.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- sum  output  W  wide sum, registered.
- cout  output  1  carry out of the most-significant word, registered.
- busy  output  1  high in RUN state.

Behaviour:
- Reset (async, rst=1): state=IDLE, in_ready=1, out_valid=0, busy=0, sum=0, cout=0, idx=0, carry reg=0. Operand registers are cleared.
- FSM states: IDLE, RUN, DONE.
- IDLE: in_ready=1.
  - On edge with in_valid&&in_ready: capture a, b and cin into registers (carry reg<=cin), idx<=0, sum<=0, go to RUN.
  - Otherwise stay in IDLE.
- RUN: in_ready=0, busy=1.
  - Adder inputs: A=a_reg word idx, B=b_reg word idx, Cin=carry reg.
  - Each edge: sum word idx <= adder Sum, carry reg <= adder Cout, idx<=idx+1.
  - On the edge where idx==WORDS-1: cout<=adder Cout, go to DONE.
- DONE: out_valid=1; sum and cout stable.
  - On edge with out_ready=1: go to IDLE, out_valid<=0.
  - out_ready low holds DONE indefinitely. sum and cout must not change while out_valid=1.
- Latency: out_valid rises exactly WORDS cycles after the accepting edge.
- Minimum issue interval: WORDS+2 cycles. No new operands are accepted in RUN or DONE.
- in_valid while not ready is ignored. The producer must hold its operands until it sees in_ready.
- Arithmetic: {cout,sum} = a + b + cin, modulo 2^(W+1). Words are processed LSW first.
- WORDS=1: RUN lasts one cycle; DONE follows on the next edge.
- idx width = max(1, clog2(WORDS)). It never exceeds WORDS-1.
- Reset mid-RUN or mid-DONE: immediate return to IDLE with all outputs at reset values. The partial result is discarded.
- sum and cout keep their last result after DONE→IDLE until the next accept clears sum.

Optional Feature:
- Macro RCA_CTRL_SUB_EN.
- When defined:
  - Extra input port sub (1 bit) is sampled with the operands at accept.
  - If sub=1: B word is fed inverted to the adder and the initial carry reg is forced to 1 (cin ignored), giving a - b.
  - cout=1 means no borrow.
- When undefined: no sub port, addition only, identical to the base behaviour above.

Test Plan:
- WORDS=4, a=1, b=2, cin=0:
  - sum=3, cout=0.
  - out_valid rises exactly 4 cycles after the accept edge; in_ready=0 during RUN.
- a=all-ones (128'hFFFF…F), b=1, cin=0:
  - sum=0, cout=1; carry chains through all 4 words.
- a=128'hAAAA…A, b=128'h5555…5, cin=1:
  - sum=0, cout=1.
- Backpressure on a=32'h12345678 in word0 / b=32'h87654321 in word0 (upper words 0), cin=1:
  - hold out_ready=0 for 5 cycles → sum word0=32'h9999999A stays stable and out_valid stays 1.
  - then out_ready=1 → IDLE next cycle.
- Reset at RUN idx=2:
  - out_valid=0, in_ready=1, sum=0 immediately.
  - a following operation 5+7 gives sum=12 with correct latency.
- RCA_CTRL_SUB_EN defined:
  - a=5, b=7, sub=1 → sum=2^128-2, cout=0.
  - a=7, b=5 → sum=2, cout=1.

Source files
------------

// File: rtl/rca_multiword_add_ctrl.sv
// Multi-word adder sequencer: one 32-bit ripple-carry adder is reused over WORDS cycles, LSW first.
// Optional subtract mode is enabled by defining RCA_CTRL_SUB_EN.
module ripple_carry_adder_32bit (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    output logic [31:0] sum,
    output logic        cout
);
    logic [32:0] c;

    always_comb begin
        sum  = '0;
        c    = '0;
        c[0] = cin;
        for (int i = 0; i < 32; i++) begin
            sum[i]   = a[i] ^ b[i] ^ c[i];
            c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
        cout = c[32];
    end
endmodule

module rca_multiword_add_ctrl #(
    parameter int unsigned WORDS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [32*WORDS-1:0] a,
    input  logic [32*WORDS-1:0] b,
    input  logic                cin,
`ifdef RCA_CTRL_SUB_EN
    input  logic                sub,
`endif
    output logic                out_valid,
    input  logic                out_ready,
    output logic [32*WORDS-1:0] sum,
    output logic                cout,
    output logic                busy
);
    localparam int unsigned W  = 32 * WORDS;
    localparam int unsigned IW = (WORDS > 1) ? $clog2(WORDS) : 1;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    a_q, b_q, sum_q;
    logic            carry_q, cout_q;
    logic [IW-1:0]   idx_q;
    logic [31:0]     add_a, add_b, add_sum;
    logic            add_cout, last, sub_sel;

`ifdef RCA_CTRL_SUB_EN
    logic sub_q;
    assign sub_sel = sub_q;
`else
    assign sub_sel = 1'b0;
`endif

    assign last  = (idx_q == IW'(WORDS - 1));
    assign add_a = a_q[32*idx_q +: 32];
    // Subtraction is a + ~b + 1; the +1 comes from the preset carry at accept.
    assign add_b = b_q[32*idx_q +: 32] ^ {32{sub_sel}};

    ripple_carry_adder_32bit u_adder (
        .a    (add_a),
        .b    (add_b),
        .cin  (carry_q),
        .sum  (add_sum),
        .cout (add_cout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        unique case (state_q)
            StIdle: begin
                in_ready = 1'b1;
                if (in_valid) state_d = StRun;
            end
            StRun: begin
                busy = 1'b1;
                if (last) state_d = StDone;
            end
            StDone: begin
                out_valid = 1'b1;
                if (out_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            idx_q   <= '0;
`ifdef RCA_CTRL_SUB_EN
            sub_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        a_q     <= a;
                        b_q     <= b;
                        idx_q   <= '0;
                        sum_q   <= '0;
`ifdef RCA_CTRL_SUB_EN
                        sub_q   <= sub;
                        carry_q <= sub | cin;
`else
                        carry_q <= cin;
`endif
                    end
                end
                StRun: begin
                    sum_q[32*idx_q +: 32] <= add_sum;
                    carry_q               <= add_cout;
                    if (last) begin
                        cout_q <= add_cout;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;
endmodule

// File: tb/tb_rca_multiword_add_ctrl.sv
// Scoreboard bench for rca_multiword_add_ctrl: reference sums queued at accept, checked at output.
// Subtract cases run only when RCA_CTRL_SUB_EN is defined.
module tb_rca_multiword_add_ctrl;
    localparam int unsigned WORDS = 4;
    localparam int unsigned W     = 32 * WORDS;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         sub = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] sum;
    logic         cout;
    logic         busy;

    int n_checks = 0;
    int n_pass   = 0;
    logic [W:0] exp_q[$];

    always #5 clk = ~clk;

    rca_multiword_add_ctrl #(.WORDS(WORDS)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
`ifdef RCA_CTRL_SUB_EN
        .sub       (sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .busy      (busy)
    );

    task automatic check_eq(input string tag, input logic [W:0] obs, input logic [W:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    // Present operands, push reference result, return at the negedge after the accept edge.
    task automatic accept(input logic [W-1:0] a_v, input logic [W-1:0] b_v,
                          input logic cin_v, input logic sub_v);
        int guard = 0;
        @(negedge clk);
        a = a_v; b = b_v; cin = cin_v; sub = sub_v; in_valid = 1'b1;
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check_eq("in_ready_wait", {{W{1'b0}}, in_ready}, 1);
`ifdef RCA_CTRL_SUB_EN
        if (sub_v) exp_q.push_back({1'b0, a_v} + {1'b0, ~b_v} + 1);
        else exp_q.push_back({1'b0, a_v} + {1'b0, b_v} + cin_v);
`else
        exp_q.push_back({1'b0, a_v} + {1'b0, b_v} + cin_v);
`endif
        @(posedge clk);
        @(negedge clk);
        // Junk on the inputs while busy must be ignored.
        a = ~a_v; b = {W{1'b1}}; cin = ~cin_v;
    endtask

    task automatic finish_op(input int hold);
        int lat = 0;
        logic [W:0] got, hold_val;
        check_eq("run_in_ready", {{W{1'b0}}, in_ready}, 0);
        check_eq("run_busy", {{W{1'b0}}, busy}, 1);
        while (!out_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        in_valid = 1'b0;
        check_eq("latency", W'(lat), W'(WORDS));
        hold_val = {cout, sum};
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check_eq("hold_valid", {{W{1'b0}}, out_valid}, 1);
            check_eq("hold_stable", {cout, sum}, hold_val);
        end
        out_ready = 1'b1;
        got = {cout, sum};
        if (exp_q.size() == 0) begin
            check_eq("sb_empty", 1, 0);
        end else begin
            check_eq("result", got, exp_q.pop_front());
        end
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check_eq("back_idle_valid", {{W{1'b0}}, out_valid}, 0);
        check_eq("back_idle_ready", {{W{1'b0}}, in_ready}, 1);
        check_eq("sum_retained", {cout, sum}, got);
    endtask

    initial begin
        logic [W-1:0] ra, rb;
        #2;
        check_eq("rst_in_ready", {{W{1'b0}}, in_ready}, 1);
        check_eq("rst_out_valid", {{W{1'b0}}, out_valid}, 0);
        check_eq("rst_busy", {{W{1'b0}}, busy}, 0);
        check_eq("rst_result", {cout, sum}, 0);
        @(negedge clk);
        rst = 1'b0;

        accept(1, 2, 1'b0, 1'b0);
        finish_op(0);
        accept('1, 1, 1'b0, 1'b0);
        finish_op(0);
        accept({4{32'hAAAAAAAA}}, {4{32'h55555555}}, 1'b1, 1'b0);
        finish_op(0);
        accept(32'h12345678, 32'h87654321, 1'b1, 1'b0);
        finish_op(5);
        check_eq("bp_word0", {{(W-31){1'b0}}, sum[31:0]}, 32'h9999999A);

        // Reset while RUN is at idx 2.
        accept({4{32'hFFFFFFFF}}, 3, 1'b1, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_eq("mid_rst_valid", {{W{1'b0}}, out_valid}, 0);
        check_eq("mid_rst_ready", {{W{1'b0}}, in_ready}, 1);
        check_eq("mid_rst_result", {cout, sum}, 0);
        check_eq("mid_rst_busy", {{W{1'b0}}, busy}, 0);
        void'(exp_q.pop_back());
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        accept(5, 7, 1'b0, 1'b0);
        finish_op(1);
        check_eq("after_rst_sum", {1'b0, sum}, 12);

        for (int k = 0; k < 4; k++) begin
            ra = {$urandom, $urandom, $urandom, $urandom};
            rb = {$urandom, $urandom, $urandom, $urandom};
            accept(ra, rb, k[0], 1'b0);
            finish_op(k);
        end

`ifdef RCA_CTRL_SUB_EN
        accept(5, 7, 1'b0, 1'b1);
        finish_op(0);
        check_eq("sub_neg", {cout, sum}, {1'b0, {(W-2){1'b1}}, 2'b10});
        accept(7, 5, 1'b0, 1'b1);
        finish_op(0);
        check_eq("sub_pos", {cout, sum}, {1'b1, {(W-2){1'b0}}, 2'b10});
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
